// File: rtl/usr_pkg.sv
// Shared types and constants for the universal shift register.
package usr_pkg;

  localparam int MODE_W = 2;

  // Operation selected by Mode_In.
  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage : usr_pkg

// File: rtl/usr_shift_counter.sv
// Counts accepted shifts and emits a one-cycle pulse on each full word.
// A load restarts the count; reset clears count and pulse.
module usr_shift_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             shift_i,
  input  logic             load_i,
  output logic [CNT_W-1:0] count_o,
  output logic             word_done_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

  logic [CNT_W-1:0] count_d, count_q;
  logic             word_done_d, word_done_q;

  // Next count and word-done pulse; the pulse is only ever one cycle wide.
  always_comb begin
    count_d     = count_q;
    word_done_d = 1'b0;
    if (load_i) begin
      count_d = ZERO_CNT;
    end else if (shift_i) begin
      if (count_q == LAST_CNT) begin
        count_d     = ZERO_CNT;
        word_done_d = 1'b1;
      end else begin
        count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      count_d = count_q;
    end
  end

  // Counter and pulse registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q     <= ZERO_CNT;
      word_done_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      word_done_q <= word_done_d;
    end
  end

  assign count_o     = count_q;
  assign word_done_o = word_done_q;

endmodule : usr_shift_counter

// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift right, shift left, parallel load.
// Optional feature macro: USR_ROTATE_EN adds Rotate_In, which turns shifts
// into rotates (serial inputs ignored while it is high).
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     Clk_In,
  input  logic                     Reset_In,
  input  logic                     Enable_In,
  input  logic [MODE_W-1:0]        Mode_In,
  input  logic                     Serial_Data_Msb_In,
  input  logic                     Serial_Data_Lsb_In,
  input  logic [WIDTH-1:0]         Parallel_Data_In,
`ifdef USR_ROTATE_EN
  input  logic                     Rotate_In,
`endif
  output logic [WIDTH-1:0]         Shift_Register_Out,
  output logic                     Serial_Data_Msb_Out,
  output logic                     Serial_Data_Lsb_Out,
  output logic [$clog2(WIDTH)-1:0] Shift_Count_Out,
  output logic                     Word_Done_Out
);

  localparam int CNT_W = $clog2(WIDTH);

  mode_e            mode_s;
  logic [WIDTH-1:0] shift_reg_d, shift_reg_q;
  logic             msb_feed_s, lsb_feed_s;
  logic             shift_acc_s, load_acc_s;

  assign mode_s = mode_e'(Mode_In);

  // Select the bits fed into the vacated end: serial inputs or wrap-around.
  always_comb begin
    msb_feed_s = Serial_Data_Msb_In;
    lsb_feed_s = Serial_Data_Lsb_In;
`ifdef USR_ROTATE_EN
    if (Rotate_In) begin
      msb_feed_s = shift_reg_q[0];
      lsb_feed_s = shift_reg_q[WIDTH-1];
    end else begin
      msb_feed_s = Serial_Data_Msb_In;
      lsb_feed_s = Serial_Data_Lsb_In;
    end
`endif
  end

  // Next register value and accept strobes for the counter.
  always_comb begin
    shift_reg_d = shift_reg_q;
    shift_acc_s = 1'b0;
    load_acc_s  = 1'b0;
    if (Enable_In) begin
      case (mode_s)
        MODE_HOLD: shift_reg_d = shift_reg_q;
        MODE_SHR: begin
          shift_reg_d = {msb_feed_s, shift_reg_q[WIDTH-1:1]};
          shift_acc_s = 1'b1;
        end
        MODE_SHL: begin
          shift_reg_d = {shift_reg_q[WIDTH-2:0], lsb_feed_s};
          shift_acc_s = 1'b1;
        end
        MODE_LOAD: begin
          shift_reg_d = Parallel_Data_In;
          load_acc_s  = 1'b1;
        end
        default: shift_reg_d = shift_reg_q;
      endcase
    end else begin
      shift_reg_d = shift_reg_q;
    end
  end

  // Data register with synchronous reset overriding every operation.
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      shift_reg_q <= {WIDTH{1'b0}};
    end else begin
      shift_reg_q <= shift_reg_d;
    end
  end

  usr_shift_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_shift_counter (
    .clk_i       (Clk_In),
    .rst_i       (Reset_In),
    .shift_i     (shift_acc_s),
    .load_i      (load_acc_s),
    .count_o     (Shift_Count_Out),
    .word_done_o (Word_Done_Out)
  );

  assign Shift_Register_Out  = shift_reg_q;
  assign Serial_Data_Msb_Out = shift_reg_q[WIDTH-1];
  assign Serial_Data_Lsb_Out = shift_reg_q[0];

endmodule : universal_shift_register

// File: tb/tb_universal_shift_register.sv
// Directed, table-driven bench for universal_shift_register at WIDTH=8.
// Rotate sequence is compiled in when USR_ROTATE_EN is defined.
module tb_universal_shift_register;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       msb_in;
  logic       lsb_in;
  logic [7:0] pdata;
  logic       rot;
  logic [7:0] reg_out;
  logic       msb_out;
  logic       lsb_out;
  logic [2:0] cnt_out;
  logic       done_out;

  int checks;
  int failures;

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       msb_in;
    logic       lsb_in;
    logic [7:0] pdata;
    logic [7:0] exp_reg;
    logic [2:0] exp_cnt;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];

  universal_shift_register #(.WIDTH(8)) dut (
    .Clk_In              (clk),
    .Reset_In            (rst),
    .Enable_In           (en),
    .Mode_In             (mode),
    .Serial_Data_Msb_In  (msb_in),
    .Serial_Data_Lsb_In  (lsb_in),
    .Parallel_Data_In    (pdata),
`ifdef USR_ROTATE_EN
    .Rotate_In           (rot),
`endif
    .Shift_Register_Out  (reg_out),
    .Serial_Data_Msb_Out (msb_out),
    .Serial_Data_Lsb_Out (lsb_out),
    .Shift_Count_Out     (cnt_out),
    .Word_Done_Out       (done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=0x%0h expected=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [1:0] m, input logic mi, input logic li,
                     input logic [7:0] pd, input logic [7:0] er, input logic [2:0] ec, input logic ed);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.msb_in = mi; v.lsb_in = li; v.pdata = pd;
    v.exp_reg = er; v.exp_cnt = ec; v.exp_done = ed;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] m, input logic mi, input logic li,
                       input logic [7:0] pd);
    rst = r; en = e; mode = m; msb_in = mi; lsb_in = li; pdata = pd;
  endtask

  // Checks all observable outputs after an edge against expected register/count/pulse.
  task automatic check_state(input string tag, input int idx, input logic [7:0] er, input logic [2:0] ec, input logic ed);
    logic [7:0] e;
    e = er;
    check({tag, "_reg"},  idx, 64'(reg_out),  64'(e));
    check({tag, "_cnt"},  idx, 64'(cnt_out),  64'(ec));
    check({tag, "_done"}, idx, 64'(done_out), 64'(ed));
    check({tag, "_msbo"}, idx, 64'(msb_out),  64'(e[7]));
    check({tag, "_lsbo"}, idx, 64'(lsb_out),  64'(e[0]));
  endtask

  initial begin
    logic [7:0] msb_bits [8];
    logic [7:0] shr_exp  [8];
    checks   = 0;
    failures = 0;
    rot      = 1'b0;
    drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);

    // Reset state
    add(1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 8'hAA, 8'h00, 3'd0, 1'b0);
    // 8 shift-right with Msb_In 1,0,1,1,0,0,1,0 -> 0x4D, pulse after 8th only
    msb_bits = '{8'd1, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0};
    shr_exp  = '{8'h80, 8'h40, 8'hA0, 8'hD0, 8'h68, 8'h34, 8'h9A, 8'h4D};
    for (int i = 0; i < 8; i++) begin
      add(1'b0, 1'b1, 2'b01, msb_bits[i][0], 1'b1, 8'h00, shr_exp[i], 3'((i + 1) % 8), (i == 7) ? 1'b1 : 1'b0);
    end
    add(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 8'hFF, 8'h4D, 3'd0, 1'b0);  // hold: pulse gone, nothing moves
    // Load 0xA5 (Msb_Out=1 before the shift), shift left with Lsb_In=0 -> 0x4A
    add(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'hA5, 8'hA5, 3'd0, 1'b0);
    add(1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 8'h00, 8'h4A, 3'd1, 1'b0);
    // Mixed directions keep counting, then load clears the count
    add(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 8'h00, 8'h95, 3'd2, 1'b0);
    add(1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 8'h00, 8'h4A, 3'd3, 1'b0);
    add(1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 8'h00, 8'h94, 3'd4, 1'b0);
    add(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'h3C, 8'h3C, 3'd0, 1'b0);
    // 7 shifts with no pulse, 8th shift pulses
    shr_exp = '{8'h9E, 8'hCF, 8'hE7, 8'hF3, 8'hF9, 8'hFC, 8'hFE, 8'hFF};
    for (int i = 0; i < 8; i++) begin
      add(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 8'h00, shr_exp[i], 3'((i + 1) % 8), (i == 7) ? 1'b1 : 1'b0);
    end
    // Pulse must drop even while disabled
    add(1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 8'hFF, 3'd0, 1'b0);
    add(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 8'hFE, 3'd1, 1'b0);
    // Enable low with Mode=01 for 5 cycles: full hold
    for (int i = 0; i < 5; i++) begin
      add(1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 8'h00, 8'hFE, 3'd1, 1'b0);
    end
    add(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00, 8'hFE, 3'd1, 1'b0);
    // Load 0xFF, 4 shifts, reset mid-word
    add(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'hFF, 8'hFF, 3'd0, 1'b0);
    add(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 8'h7F, 3'd1, 1'b0);
    add(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 8'h3F, 3'd2, 1'b0);
    add(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 8'h1F, 3'd3, 1'b0);
    add(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 8'h0F, 3'd4, 1'b0);
    add(1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 8'hAA, 8'h00, 3'd0, 1'b0);
    // Count restarts from zero: pulse only after 8 fresh shifts
    shr_exp = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    for (int i = 0; i < 8; i++) begin
      add(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 8'h00, shr_exp[i], 3'((i + 1) % 8), (i == 7) ? 1'b1 : 1'b0);
    end
    // Load with the counter at 7 clears it and gives no pulse
    shr_exp = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
    for (int i = 0; i < 7; i++) begin
      add(1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 8'h00, shr_exp[i], 3'(i + 1), 1'b0);
    end
    add(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'h5A, 8'h5A, 3'd0, 1'b0);
    add(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 8'h00, 8'h5A, 3'd0, 1'b0);

    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].msb_in, vecs[i].lsb_in, vecs[i].pdata);
      @(posedge clk);
      #1;
      check_state("vec", i, vecs[i].exp_reg, vecs[i].exp_cnt, vecs[i].exp_done);
      @(negedge clk);
    end

    // Msb_Out readout before the shift edge, with zero latency after a load
    drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'hA5);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 8'h00);
    check("pre_shift_msbo", 0, 64'(msb_out), 64'(1));
    @(posedge clk); #1;
    check_state("shl", 0, 8'h4A, 3'd1, 1'b0);

`ifdef USR_ROTATE_EN
    // Rotate: serial inputs chosen so that a plain shift would differ
    drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'h81);
    rot = 1'b0;
    @(posedge clk); #1;
    check_state("rot_load", 0, 8'h81, 3'd0, 1'b0);
    rot = 1'b1;
    drive(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
    @(posedge clk); #1;
    check_state("rot_shr", 0, 8'hC0, 3'd1, 1'b0);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 8'h00);
    @(posedge clk); #1;
    check_state("rot_shl", 0, 8'h81, 3'd2, 1'b0);
    rot = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_universal_shift_register

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register length in bits; legal range 2..64.
REQ-002 The block SHALL have port Clk_In  input  1  single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port Reset_In  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port Enable_In  input  1  operation qualifier; low = full hold.
REQ-005 The block SHALL have port Mode_In  input  2  operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-006 The block SHALL have port Serial_Data_Msb_In  input  1  bit entering bit WIDTH-1 on shift right.
REQ-007 The block SHALL have port Serial_Data_Lsb_In  input  1  bit entering bit 0 on shift left.
REQ-008 The block SHALL have port Parallel_Data_In  input  WIDTH  load value.
REQ-009 The block SHALL have port Shift_Register_Out  output  WIDTH  current register contents.
REQ-010 The block SHALL have port Serial_Data_Msb_Out  output  1  bit WIDTH-1 of the register, combinational from the register.
REQ-011 The block SHALL have port Serial_Data_Lsb_Out  output  1  bit 0 of the register, combinational from the register.
REQ-012 The block SHALL have port Shift_Count_Out  output  $clog2(WIDTH)  accepted shifts since last reset, load or wrap.
REQ-013 The block SHALL have port Word_Done_Out  output  1  registered one-cycle pulse: WIDTH shifts completed.

Function
REQ-014 An operation SHALL be accepted only on an edge with Reset_In low and Enable_In high; otherwise register and counter hold.
REQ-015 Shift right SHALL set bit i to bit i+1 for i < WIDTH-1, with bit WIDTH-1 taking Serial_Data_Msb_In.
REQ-016 Shift left SHALL set bit i to bit i-1 for i > 0, with bit 0 taking Serial_Data_Lsb_In.
REQ-017 Parallel load SHALL set the register to Parallel_Data_In and the counter to 0, with Word_Done_Out low on the next cycle.
REQ-018 Each accepted shift in either direction SHALL increment the counter; a direction change SHALL NOT clear it.
REQ-019 An accepted shift with the counter at WIDTH-1 SHALL wrap the counter to 0 and drive Word_Done_Out high for exactly the next cycle.
REQ-020 Word_Done_Out SHALL be low on every cycle not covered by REQ-019, including while Enable_In is low.
REQ-021 Hold mode SHALL leave register and counter unchanged.
REQ-022 Serial outputs SHALL reflect the post-edge register, giving zero-latency readout of the next bit to leave.

Reset
REQ-023 Reset_In high at an edge SHALL clear the register, counter and Word_Done_Out to 0, overriding Enable_In and Mode_In.
REQ-024 Reset asserted mid-word SHALL discard the partial count, and no Word_Done_Out pulse SHALL follow it.

Configuration
REQ-025 With macro USR_ROTATE_EN defined, the block SHALL add port Rotate_In (input, 1 bit); when it is high, shifts SHALL rotate: shift right feeds bit 0 into bit WIDTH-1, shift left feeds bit WIDTH-1 into bit 0, and the serial inputs are ignored.
REQ-026 Rotates SHALL count as shifts for REQ-018/019.
REQ-027 Without USR_ROTATE_EN, Rotate_In SHALL NOT exist and shifts SHALL always use the serial inputs.

Structure
REQ-028 Package usr_pkg SHALL hold the mode enum (MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD) and the mode width constant.
REQ-029 The shift counter and wrap/pulse logic SHALL be a sub-module usr_shift_counter, parameterised by WIDTH.

Verification (WIDTH=8)
REQ-030 The bench SHALL check: reset, then 8 shift-right with Msb_In 1,0,1,1,0,0,1,0 -> register 0x4D, count 0, Word_Done_Out high only the cycle after the 8th edge.
REQ-031 The bench SHALL check: load 0xA5, then one shift left with Lsb_In=0 -> Msb_Out 1 before the edge, register 0x4A, count 1.
REQ-032 The bench SHALL check: 3 shifts, load 0x3C -> count 0; a further 7 shifts give no pulse; the 8th shift gives a pulse.
REQ-033 The bench SHALL check: Enable_In low with Mode_In=01 for 5 cycles -> register, count unchanged; Word_Done_Out low.
REQ-034 The bench SHALL check: load 0xFF, 4 shifts, Reset_In high for 1 cycle -> register 0x00, count 0, no pulse afterwards.
REQ-035 The bench SHALL check, with USR_ROTATE_EN defined: load 0x81, Rotate_In=1, one shift right -> 0xC0; then one shift left -> 0x81.
